// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester arbiter in front of a single-port synchronous data memory
// (BRAM with one-cycle read latency). M0 is the CPU load/store unit and M1 is
// the debug/DMA loader. M0 has fixed priority. After M1 has been blocked for
// MAX_WAIT consecutive cycles, M1 wins the next contended arbitration.
//
// The owner of each accepted access is registered, so read data returning one
// cycle later goes only to the requester that issued the read. An access whose
// word index is at or beyond DEPTH_WORDS is still granted. Its memory write is
// suppressed, and it produces a one-cycle error pulse instead of read data.
//
// Parameters:
//   DEPTH_WORDS  memory depth in 32-bit words (valid word index 0..DEPTH_WORDS-1)
//   MAX_WAIT     blocked M1 cycles before M1 is forced to win once
//   CNT_W        starvation counter width; must be able to hold MAX_WAIT
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   mX_req/we/addr      request, write enable, byte address (word = addr[31:2])
//   mX_wdata_sel/wdata  byte-lane write mask and write data
//   mX_gnt              request accepted this cycle (combinational)
//   mX_rvalid/rdata     read data, one cycle after acceptance (rdata 0 otherwise)
//   mX_err              out-of-range response, one cycle after acceptance
//   mem_we/addr/...     memory drive, muxed from the winner (M0 fields when idle)
//   mem_rdata           memory read data, valid one cycle after the address
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DEPTH_WORDS = 131072,
  parameter int MAX_WAIT    = 4,
  parameter int CNT_W       = 3
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_wdata_sel,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_wdata_sel,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,

  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wdata_sel,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [29:0]      DEPTH_LIMIT = 30'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_LIMIT  = CNT_W'(MAX_WAIT);

  // Owner encoding of the in-flight response: 0 = M0, 1 = M1.
  logic             resp_vld;
  logic             resp_owner;
  logic             resp_rd;
  logic             resp_err;
  logic [CNT_W-1:0] starve_cnt;

  logic             any_gnt;
  logic             sel_we;
  logic             in_range;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block is given a default before any
  // branch, so no path can leave it unassigned and infer a latch.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    // Grants are combinational, so they would follow the requests even while
    // the registered state is held in reset. They are gated explicitly.
    if (!reset) begin
      if (m0_req && m1_req) begin
        if (starve_cnt == WAIT_LIMIT) begin
          m1_gnt = 1'b1;
        end else begin
          m0_gnt = 1'b1;
        end
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  assign any_gnt = m0_gnt | m1_gnt;

  // ---------------------------------------------------------------------------
  // Memory drive: the M1 fields are used only when M1 actually wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_we        = m0_we;
    mem_addr      = m0_addr;
    mem_wdata_sel = m0_wdata_sel;
    mem_wdata     = m0_wdata;
    if (m1_gnt) begin
      sel_we        = m1_we;
      mem_addr      = m1_addr;
      mem_wdata_sel = m1_wdata_sel;
      mem_wdata     = m1_wdata;
    end
  end

  // The byte offset plays no part in the range check.
  assign in_range = (mem_addr[31:2] < DEPTH_LIMIT);
  assign mem_we   = any_gnt & sel_we & in_range;

  // ---------------------------------------------------------------------------
  // Starvation counter and response tracking
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking assignments, so every
  // register samples the values that were present before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      resp_vld   <= 1'b0;
      resp_owner <= 1'b0;
      resp_rd    <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      if (m1_req && !m1_gnt) begin
        if (starve_cnt != WAIT_LIMIT) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
      // The response registers update every cycle. Without an accept,
      // resp_vld drops and the other fields have no effect.
      resp_vld   <= any_gnt;
      resp_owner <= m1_gnt;
      resp_rd    <= ~sel_we;
      resp_err   <= ~in_range;
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  assign m0_rvalid = resp_vld & resp_rd & ~resp_err & ~resp_owner;
  assign m1_rvalid = resp_vld & resp_rd & ~resp_err &  resp_owner;
  assign m0_err    = resp_vld & resp_err & ~resp_owner;
  assign m1_err    = resp_vld & resp_err &  resp_owner;
  assign m0_rdata  = m0_rvalid ? mem_rdata : 32'h0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed scenarios for dmem_arbiter, followed by a randomized run. The
// randomized run is checked against a transaction-level model. That model
// holds a word-addressed shadow memory, a count of consecutive cycles in which
// M1 has waited, and the single response expected in the following cycle.
// A behavioural BRAM with one-cycle read latency sits on the memory port.
// Inputs change just after the falling edge, and outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int DEPTH_WORDS = 131072;
  localparam int MAX_WAIT    = 4;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wdata_sel;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wdata_sel;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wdata_sel;
  logic [31:0] mem_rdata = 32'h0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .MAX_WAIT   (MAX_WAIT),
    .CNT_W      (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m0_req       (m0_req),
    .m0_we        (m0_we),
    .m0_addr      (m0_addr),
    .m0_wdata_sel (m0_wdata_sel),
    .m0_wdata     (m0_wdata),
    .m0_gnt       (m0_gnt),
    .m0_rvalid    (m0_rvalid),
    .m0_rdata     (m0_rdata),
    .m0_err       (m0_err),
    .m1_req       (m1_req),
    .m1_we        (m1_we),
    .m1_addr      (m1_addr),
    .m1_wdata_sel (m1_wdata_sel),
    .m1_wdata     (m1_wdata),
    .m1_gnt       (m1_gnt),
    .m1_rvalid    (m1_rvalid),
    .m1_rdata     (m1_rdata),
    .m1_err       (m1_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata_sel(mem_wdata_sel),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Behavioural BRAM: byte-lane writes, read-first, one-cycle read latency.
  logic [31:0] bram [0:DEPTH_WORDS-1] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wdata_sel[b]) bram[mem_addr[18:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    mem_rdata <= bram[mem_addr[18:2]];
  end

  // Shadow memory of the reference model, indexed by word.
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_read(logic [31:0] a);
    int k = int'(a[31:2]);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  function automatic void ref_write(logic [31:0] a, logic [3:0] sel, logic [31:0] d);
    logic [31:0] w = ref_read(a);
    for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[int'(a[31:2])] = w;
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned k = $urandom_range(0, 9);
    logic [29:0] w;
    if (k < 6)      w = 30'($urandom_range(0, 63));
    else if (k < 9) w = 30'(DEPTH_WORDS - 2 + int'($urandom_range(0, 3)));
    else            w = 30'($urandom);
    return {w, 2'($urandom_range(0, 3))};
  endfunction

  function automatic req_t new_req(int pct);
    req_t r;
    r.req   = ($urandom_range(0, 99) < pct);
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = rand_addr();
    r.sel   = 4'($urandom_range(0, 15));
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic set_m0(logic req, logic we, logic [31:0] a, logic [3:0] sel, logic [31:0] d);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata_sel = sel; m0_wdata = d;
  endtask

  task automatic set_m1(logic req, logic we, logic [31:0] a, logic [3:0] sel, logic [31:0] d);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata_sel = sel; m1_wdata = d;
  endtask

  task automatic idle();
    set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    set_m0(1'b1, 1'b1, 32'h10, 4'hF, 32'h1234_5678);
    set_m1(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
    #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin failures++; $display("FAIL rst_gnt: got %b want 00", {m0_gnt, m1_gnt}); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    checks++; if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0000) begin failures++; $display("FAIL rst_resp: got %b want 0000", {m0_rvalid, m1_rvalid, m0_err, m1_err}); end
    checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin failures++; $display("FAIL rst_rdata: got %h want 0", {m0_rdata, m1_rdata}); end
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    checks++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err} !== 6'b0) begin failures++; $display("FAIL rst_release: got %b want 000000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err}); end
    checks++; if (dut.starve_cnt !== 3'd0) begin failures++; $display("FAIL rst_starve: got %0d want 0", dut.starve_cnt); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_read();
    @(negedge clk);
    set_m0(1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
    #1;
    checks++; if ({m0_gnt, mem_we} !== 2'b11) begin failures++; $display("FAIL sr_wr_gnt: got gnt/we %b want 11", {m0_gnt, mem_we}); end
    ref_write(32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    set_m0(1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
    #1;
    checks++; if ({m0_gnt, m1_gnt, mem_we} !== 3'b100) begin failures++; $display("FAIL sr_rd_gnt: got %b want 100", {m0_gnt, m1_gnt, mem_we}); end
    checks++; if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL sr_wr_no_rvalid: got %b want 0", m0_rvalid); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (m0_rvalid !== 1'b1) begin failures++; $display("FAIL sr_rvalid: got %b want 1", m0_rvalid); end
    checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sr_rdata: got %h want deadbeef", m0_rdata); end
    checks++; if ({m1_rvalid, m1_err, m0_err, m1_rdata} !== 35'h0) begin failures++; $display("FAIL sr_m1_quiet: got %b/%b/%b/%h want 0", m1_rvalid, m1_err, m0_err, m1_rdata); end
    idle_cycles(1);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_starvation();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      set_m0(1'b1, 1'b0, 32'h0000_0020, 4'h0, 32'h0);
      set_m1(1'b1, 1'b0, 32'h0000_0024, 4'h0, 32'h0);
      #1;
      checks++; if ({m0_gnt, m1_gnt} !== ((c == 4) ? 2'b01 : 2'b10)) begin failures++; $display("FAIL starve_gnt c%0d: got %b want %b", c, {m0_gnt, m1_gnt}, (c == 4) ? 2'b01 : 2'b10); end
      if (c > 0) begin
        checks++; if ({m0_rvalid, m1_rvalid} !== ((c == 5) ? 2'b01 : 2'b10)) begin failures++; $display("FAIL starve_route c%0d: got %b want %b", c, {m0_rvalid, m1_rvalid}, (c == 5) ? 2'b01 : 2'b10); end
      end
      if (c == 5) begin
        checks++; if (dut.starve_cnt !== 3'd0) begin failures++; $display("FAIL starve_clear: got %0d want 0", dut.starve_cnt); end
      end
    end
    idle_cycles(2);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_interleaved();
    @(negedge clk);
    set_m0(1'b1, 1'b1, 32'h0000_00A0, 4'hF, 32'h1111_A0A0);
    ref_write(32'h0000_00A0, 4'hF, 32'h1111_A0A0);
    @(negedge clk);
    set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_m1(1'b1, 1'b1, 32'h0000_00A4, 4'hF, 32'h2222_B0B0);
    #1;
    checks++; if ({m1_gnt, mem_we} !== 2'b11) begin failures++; $display("FAIL il_m1_wr: got %b want 11", {m1_gnt, mem_we}); end
    ref_write(32'h0000_00A4, 4'hF, 32'h2222_B0B0);
    @(negedge clk);
    set_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_m0(1'b1, 1'b0, 32'h0000_00A0, 4'h0, 32'h0);
    #1;
    checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL il_m0_gnt: got %b want 1", m0_gnt); end
    @(negedge clk);
    set_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_m1(1'b1, 1'b0, 32'h0000_00A4, 4'h0, 32'h0);
    #1;
    checks++; if (m1_gnt !== 1'b1) begin failures++; $display("FAIL il_m1_gnt: got %b want 1", m1_gnt); end
    checks++; if ({m0_rvalid, m0_rdata} !== {1'b1, 32'h1111_A0A0}) begin failures++; $display("FAIL il_a: got %b/%h want 1/1111a0a0", m0_rvalid, m0_rdata); end
    checks++; if ({m1_rvalid, m1_rdata} !== 33'h0) begin failures++; $display("FAIL il_a_cross: got %b/%h want 0/0", m1_rvalid, m1_rdata); end
    @(negedge clk);
    idle();
    #1;
    checks++; if ({m1_rvalid, m1_rdata} !== {1'b1, 32'h2222_B0B0}) begin failures++; $display("FAIL il_b: got %b/%h want 1/2222b0b0", m1_rvalid, m1_rdata); end
    checks++; if ({m0_rvalid, m0_rdata} !== 33'h0) begin failures++; $display("FAIL il_b_cross: got %b/%h want 0/0", m0_rvalid, m0_rdata); end
    idle_cycles(1);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_out_of_range();
    @(negedge clk);
    set_m1(1'b1, 1'b1, 32'h0008_0000, 4'hF, 32'h5555_AAAA);
    #1;
    checks++; if ({m1_gnt, mem_we} !== 2'b10) begin failures++; $display("FAIL oor_wr: got gnt/we %b want 10", {m1_gnt, mem_we}); end
    @(negedge clk);
    idle();
    #1;
    checks++; if ({m1_err, m0_err, m1_rvalid} !== 3'b100) begin failures++; $display("FAIL oor_err: got %b want 100", {m1_err, m0_err, m1_rvalid}); end
    @(negedge clk);
    set_m1(1'b1, 1'b1, 32'h0007_FFFC, 4'hF, 32'hCAFE_F00D);
    #1;
    checks++; if (m1_err !== 1'b0) begin failures++; $display("FAIL oor_pulse: got %b want 0", m1_err); end
    checks++; if ({m1_gnt, mem_we} !== 2'b11) begin failures++; $display("FAIL last_word_wr: got gnt/we %b want 11", {m1_gnt, mem_we}); end
    ref_write(32'h0007_FFFC, 4'hF, 32'hCAFE_F00D);
    @(negedge clk);
    set_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    set_m0(1'b1, 1'b0, 32'h0008_0006, 4'h0, 32'h0);
    #1;
    checks++; if ({m1_err, m1_rvalid} !== 2'b00) begin failures++; $display("FAIL last_word_resp: got %b want 00", {m1_err, m1_rvalid}); end
    @(negedge clk);
    idle();
    #1;
    checks++; if ({m0_err, m0_rvalid, m0_rdata} !== {2'b10, 32'h0}) begin failures++; $display("FAIL oor_rd: got %b/%b/%h want 1/0/0", m0_err, m0_rvalid, m0_rdata); end
    idle_cycles(1);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_byte_write();
    @(negedge clk);
    set_m0(1'b1, 1'b1, 32'h0000_0100, 4'b0100, 32'h00AB_0000);
    #1;
    checks++; if ({m0_gnt, mem_we, mem_wdata_sel} !== 6'b11_0100) begin failures++; $display("FAIL bw_drive: got %b want 110100", {m0_gnt, mem_we, mem_wdata_sel}); end
    checks++; if (mem_wdata !== 32'h00AB_0000) begin failures++; $display("FAIL bw_wdata: got %h want 00ab0000", mem_wdata); end
    ref_write(32'h0000_0100, 4'b0100, 32'h00AB_0000);
    @(negedge clk);
    set_m0(1'b1, 1'b1, 32'h0000_0101, 4'b0000, 32'hFFFF_FFFF);
    #1;
    checks++; if ({m0_rvalid, m0_err} !== 2'b00) begin failures++; $display("FAIL bw_resp: got %b want 00", {m0_rvalid, m0_err}); end
    checks++; if ({m0_gnt, mem_we, mem_wdata_sel} !== 6'b11_0000) begin failures++; $display("FAIL zero_mask: got %b want 110000", {m0_gnt, mem_we, mem_wdata_sel}); end
    @(negedge clk);
    set_m0(1'b1, 1'b0, 32'h0000_0102, 4'h0, 32'h0);
    #1;
    checks++; if ({m0_rvalid, m0_err} !== 2'b00) begin failures++; $display("FAIL zero_mask_resp: got %b want 00", {m0_rvalid, m0_err}); end
    @(negedge clk);
    idle();
    #1;
    checks++; if ({m0_rvalid, m0_rdata} !== {1'b1, 32'h00AB_0000}) begin failures++; $display("FAIL bw_readback: got %b/%h want 1/00ab0000", m0_rvalid, m0_rdata); end
    idle_cycles(1);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_read();
    @(negedge clk);
    set_m0(1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
    #1;
    checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL rmr_gnt: got %b want 1", m0_gnt); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if ({m0_rvalid, m0_rdata, m0_gnt} !== 34'h0) begin failures++; $display("FAIL rmr_drop: got %b/%h/%b want 0/0/0", m0_rvalid, m0_rdata, m0_gnt); end
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin failures++; $display("FAIL rmr_after1: got %b want 00", {m0_rvalid, m1_rvalid}); end
    @(negedge clk);
    #1;
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin failures++; $display("FAIL rmr_after2: got %b want 00", {m0_rvalid, m1_rvalid}); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random(int n);
    req_t        r0 = '0, r1 = '0, w;
    logic        e0, e1, g0_prev = 1'b0, g1_prev = 1'b0, inr;
    logic        p_vld = 1'b0, p_owner = 1'b0, p_rd = 1'b0, p_err = 1'b0;
    logic [31:0] p_data = 32'h0;
    logic        x0_rv, x1_rv, x0_er, x1_er;
    int          waited = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (!r0.req || g0_prev) r0 = new_req(60);
      if (!r1.req || g1_prev) r1 = new_req(50);
      set_m0(r0.req, r0.we, r0.addr, r0.sel, r0.wdata);
      set_m1(r1.req, r1.we, r1.addr, r1.sel, r1.wdata);
      #1;
      x0_rv = p_vld && p_rd && !p_err && !p_owner;
      x1_rv = p_vld && p_rd && !p_err &&  p_owner;
      x0_er = p_vld && p_err && !p_owner;
      x1_er = p_vld && p_err &&  p_owner;
      if (r0.req && r1.req) begin
        e1 = (waited == MAX_WAIT);
        e0 = !e1;
      end else begin
        e0 = r0.req;
        e1 = r1.req;
      end
      w   = e1 ? r1 : r0;
      inr = (int'(w.addr[31:2]) < DEPTH_WORDS);
      checks++; if ({m0_gnt, m1_gnt} !== {e0, e1}) begin failures++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, {m0_gnt, m1_gnt}, {e0, e1}); end
      checks++; if (mem_we !== ((e0 || e1) && w.we && inr)) begin failures++; $display("FAIL rnd_mem_we c%0d: got %b want %b", c, mem_we, (e0 || e1) && w.we && inr); end
      checks++; if ({mem_addr, mem_wdata_sel, mem_wdata} !== {w.addr, w.sel, w.wdata}) begin failures++; $display("FAIL rnd_mem_bus c%0d: got %h/%h/%h want %h/%h/%h", c, mem_addr, mem_wdata_sel, mem_wdata, w.addr, w.sel, w.wdata); end
      checks++; if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== {x0_rv, x1_rv, x0_er, x1_er}) begin failures++; $display("FAIL rnd_resp c%0d: got %b want %b", c, {m0_rvalid, m1_rvalid, m0_err, m1_err}, {x0_rv, x1_rv, x0_er, x1_er}); end
      checks++; if (m0_rdata !== (x0_rv ? p_data : 32'h0)) begin failures++; $display("FAIL rnd_m0_rdata c%0d: got %h want %h", c, m0_rdata, x0_rv ? p_data : 32'h0); end
      checks++; if (m1_rdata !== (x1_rv ? p_data : 32'h0)) begin failures++; $display("FAIL rnd_m1_rdata c%0d: got %h want %h", c, m1_rdata, x1_rv ? p_data : 32'h0); end
      p_vld   = e0 || e1;
      p_owner = e1;
      p_rd    = !w.we;
      p_err   = !inr;
      p_data  = ref_read(w.addr);
      if (p_vld && w.we && inr) ref_write(w.addr, w.sel, w.wdata);
      if (r1.req && !e1) waited = (waited < MAX_WAIT) ? waited + 1 : MAX_WAIT;
      else               waited = 0;
      g0_prev = e0;
      g1_prev = e1;
    end
    idle_cycles(2);
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    test_reset();
    test_single_read();
    test_starvation();
    test_interleaved();
    test_out_of_range();
    test_byte_write();
    test_reset_mid_read();
    test_random(3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
